// File: rtl/i2s_tx_ctrl.sv
// I2S transmit controller: pulls L/R words from two show-ahead FIFOs and serialises them as
// Philips I2S frames (one-bit delay). Define I2S_TX_UNDERRUN_FILL_EN for zero-fill on underrun.
module i2s_tx_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              i2s_enable,
  input  logic              fifol_empty,
  input  logic              fifor_empty,
  input  logic [DATA_W-1:0] fifol_rdata,
  input  logic [DATA_W-1:0] fifor_rdata,
  output logic              fifol_pop,
  output logic              fifor_pop,
  output logic              i2s_sck,
  output logic              i2s_ws,
  output logic              i2s_sd,
  output logic              i2s_tx_done,
`ifdef I2S_TX_UNDERRUN_FILL_EN
  output logic              tx_underrun,
`endif
  output logic              busy
);

  localparam int unsigned FrameW = 2 * DATA_W;
  localparam int unsigned BitW   = $clog2(FrameW);
  localparam logic [BitW-1:0] BitLast = BitW'(FrameW - 1);
  localparam logic [BitW-1:0] WsStart = BitW'(DATA_W);
  localparam logic [7:0]      DivLast = 8'(CLK_DIV - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} state_e;

  state_e            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d, bit_nxt;
  logic [FrameW-1:0] shift_q, shift_d;
  logic              sck_q, sck_d;
  logic              ws_q, ws_d;
  logic              sd_q, sd_d;
  logic              tick, fall, can_load, load;
  logic [DATA_W-1:0] l_word, r_word;

  assign tick    = (div_q == DivLast);
  assign fall    = tick & sck_q;
  assign bit_nxt = bit_q + 1'b1;

`ifdef I2S_TX_UNDERRUN_FILL_EN
  assign can_load = i2s_enable & (~fifol_empty | ~fifor_empty);
`else
  assign can_load = i2s_enable & ~fifol_empty & ~fifor_empty;
`endif

  // An empty channel contributes zeros (only reachable with underrun fill enabled)
  always_comb begin
    l_word = fifol_empty ? '0 : fifol_rdata;
    r_word = fifor_empty ? '0 : fifor_rdata;
  end

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    sck_d       = sck_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    load        = 1'b0;
    fifol_pop   = 1'b0;
    fifor_pop   = 1'b0;
    i2s_tx_done = 1'b0;
`ifdef I2S_TX_UNDERRUN_FILL_EN
    tx_underrun = 1'b0;
`endif

    unique case (state_q)
      StIdle: begin
        if (can_load) state_d = StLoad;
      end
      StLoad: begin
        load    = 1'b1;
        state_d = StRun;
        div_d   = '0;
        bit_d   = '0;
        sck_d   = 1'b0;
        ws_d    = 1'b0;
        sd_d    = 1'b0;
      end
      StRun, StDrain: begin
        div_d = tick ? '0 : div_q + 8'd1;
        if (tick) sck_d = ~sck_q;
        if (fall) begin
          if (state_q == StDrain) begin
            state_d = StIdle;
            ws_d    = 1'b1;
            sd_d    = 1'b0;
            shift_d = '0;
          end else begin
            // Bit p goes out at the start of slot p+1: this is the one-bit WS delay
            sd_d    = shift_q[FrameW-1];
            shift_d = {shift_q[FrameW-2:0], 1'b0};
            if (bit_q == BitLast) begin
              i2s_tx_done = 1'b1;
              ws_d        = 1'b0;
              bit_d       = '0;
              if (can_load) load = 1'b1;
              else          state_d = StDrain;
            end else begin
              bit_d = bit_nxt;
              ws_d  = (bit_nxt >= WsStart);
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      fifol_pop = ~fifol_empty;
      fifor_pop = ~fifor_empty;
      shift_d   = {l_word, r_word};
`ifdef I2S_TX_UNDERRUN_FILL_EN
      tx_underrun = fifol_empty | fifor_empty;
`endif
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= StIdle;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sck_q   <= 1'b0;
      ws_q    <= 1'b1;
      sd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sck_q   <= sck_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
    end
  end

  assign i2s_sck = sck_q;
  assign i2s_ws  = ws_q;
  assign i2s_sd  = sd_q;
  assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Bench for i2s_tx_ctrl: queue-based FIFO model, serial stream capture on SCK rise, and an
// arithmetic frame model (slot k carries WS=(k mod 2W)>=W and frame bit k-1).
module tb_i2s_tx_ctrl;
  localparam int DW  = 8;
  localparam int FW  = 2 * DW;
  localparam int DIV = 3;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          i2s_enable = 1'b0;
  logic          fifol_empty = 1'b1;
  logic          fifor_empty = 1'b1;
  logic [DW-1:0] fifol_rdata = '0;
  logic [DW-1:0] fifor_rdata = '0;
  logic          fifol_pop, fifor_pop, i2s_sck, i2s_ws, i2s_sd, i2s_tx_done, busy;
`ifdef I2S_TX_UNDERRUN_FILL_EN
  logic          tx_underrun;
`endif

  i2s_tx_ctrl #(.DATA_W(DW), .CLK_DIV(DIV)) dut (
    .pclk       (pclk),
    .presetn    (presetn),
    .i2s_enable (i2s_enable),
    .fifol_empty(fifol_empty),
    .fifor_empty(fifor_empty),
    .fifol_rdata(fifol_rdata),
    .fifor_rdata(fifor_rdata),
    .fifol_pop  (fifol_pop),
    .fifor_pop  (fifor_pop),
    .i2s_sck    (i2s_sck),
    .i2s_ws     (i2s_ws),
    .i2s_sd     (i2s_sd),
    .i2s_tx_done(i2s_tx_done),
`ifdef I2S_TX_UNDERRUN_FILL_EN
    .tx_underrun(tx_underrun),
`endif
    .busy       (busy)
  );

  always #5 pclk = ~pclk;

  // FIFO model: tests append to lmem/rmem; read pointers advance one cycle after a pop
  logic [DW-1:0] lmem[$];
  logic [DW-1:0] rmem[$];
  int            lrd = 0, rrd = 0;
  logic          pend_l = 1'b0, pend_r = 1'b0, flush = 1'b0;

  always @(posedge pclk) begin
    #1;
    if (pend_l) lrd++;
    if (pend_r) rrd++;
    if (flush) begin
      lrd = lmem.size();
      rrd = rmem.size();
    end
    fifol_empty = (lrd >= lmem.size());
    fifor_empty = (rrd >= rmem.size());
    fifol_rdata = fifol_empty ? '0 : lmem[lrd];
    fifor_rdata = fifor_empty ? '0 : rmem[rrd];
  end

  // Monitor: all counters are monotonic; tests compare deltas against snapshots
  logic ws_log[$];
  logic sd_log[$];
  int   pops_l = 0, pops_r = 0, dones = 0, underruns = 0;
  int   bad_hp = 0, bad_edge = 0, bad_pop = 0, busy_rises = 0, hp_cnt = 0;
  logic sck_prev = 1'b0, ws_prev = 1'b1, sd_prev = 1'b0, busy_prev = 1'b0, in_burst = 1'b0;

  always @(negedge pclk) begin
    hp_cnt++;
    if (fifol_pop) begin pops_l++; if (fifol_empty) bad_pop++; end
    if (fifor_pop) begin pops_r++; if (fifor_empty) bad_pop++; end
    pend_l = fifol_pop;
    pend_r = fifor_pop;
    if (i2s_tx_done) dones++;
`ifdef I2S_TX_UNDERRUN_FILL_EN
    if (tx_underrun) underruns++;
`endif
    if (busy && !busy_prev) busy_rises++;
    if (i2s_sck !== sck_prev) begin
      if (in_burst && hp_cnt != DIV) bad_hp++;
      hp_cnt   = 0;
      in_burst = busy;
    end
    if (!busy) in_burst = 1'b0;
    if (i2s_sck && !sck_prev) begin
      ws_log.push_back(i2s_ws);
      sd_log.push_back(i2s_sd);
    end
    if (i2s_sck && (i2s_ws !== ws_prev || i2s_sd !== sd_prev)) bad_edge++;
    sck_prev  = i2s_sck;
    ws_prev   = i2s_ws;
    sd_prev   = i2s_sd;
    busy_prev = busy;
  end

  // Reference model over the frames expected in the current burst
  logic [FW-1:0] frames[$];
  int n_vec = 0, n_err = 0;

  function automatic logic exp_ws(input int k);
    return ((k % FW) >= DW);
  endfunction

  function automatic logic exp_sd(input int k);
    logic [FW-1:0] w;
    if (k == 0) return 1'b0;
    w = frames[(k - 1) / FW];
    return w[FW - 1 - ((k - 1) % FW)];
  endfunction

  task automatic wait_idle(input int budget, output bit ok);
    bit started = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge pclk);
      if (busy) started = 1'b1;
      else if (started) ok = 1'b1;
    end
  endtask

  task automatic wait_slots(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge pclk);
      if (ws_log.size() >= target) ok = 1'b1;
    end
  endtask

  task automatic do_flush();
    @(posedge pclk); #2 flush = 1'b1;
    @(posedge pclk); #2 flush = 1'b0;
  endtask

  task automatic test_reset();
    presetn = 1'b0;
    repeat (2) @(negedge pclk);
    n_vec++;
    if ({i2s_sck, i2s_ws, i2s_sd, busy} !== 4'b0100) begin
      n_err++; $display("FAIL reset_out sck/ws/sd/busy got %b want 0100", {i2s_sck, i2s_ws, i2s_sd, busy});
    end
    n_vec++;
    if ({fifol_pop, fifor_pop, i2s_tx_done} !== 3'b000) begin
      n_err++; $display("FAIL reset_strobes got %b want 000", {fifol_pop, fifor_pop, i2s_tx_done});
    end
    @(posedge pclk); #2 presetn = 1'b1;
    repeat (5) @(negedge pclk);
    n_vec++;
    if ({i2s_sck, i2s_ws, i2s_sd, busy} !== 4'b0100) begin
      n_err++; $display("FAIL idle_out sck/ws/sd/busy got %b want 0100", {i2s_sck, i2s_ws, i2s_sd, busy});
    end
  endtask

  task automatic test_single();
    int s0 = ws_log.size(), d0 = dones, pl0 = pops_l, pr0 = pops_r;
    int h0 = bad_hp, e0 = bad_edge, b0 = bad_pop;
    bit ok;
    frames.delete();
    frames.push_back({8'hA5, 8'h3C});
    @(posedge pclk); #2;
    lmem.push_back(8'hA5);
    rmem.push_back(8'h3C);
    i2s_enable = 1'b1;
    wait_idle(2000, ok);
    @(posedge pclk); #2 i2s_enable = 1'b0;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL single_timeout busy=%b want 0", busy); end
    n_vec++;
    if (ws_log.size() - s0 != FW + 1) begin
      n_err++; $display("FAIL single_len got %0d want %0d", ws_log.size() - s0, FW + 1);
    end
    for (int k = 0; k < FW + 1 && s0 + k < ws_log.size(); k++) begin
      n_vec++;
      if ({ws_log[s0+k], sd_log[s0+k]} !== {exp_ws(k), exp_sd(k)}) begin
        n_err++; $display("FAIL single_slot%0d ws/sd got %b%b want %b%b", k, ws_log[s0+k],
                          sd_log[s0+k], exp_ws(k), exp_sd(k));
      end
    end
    n_vec++;
    if (dones - d0 != 1) begin n_err++; $display("FAIL single_done got %0d want 1", dones - d0); end
    n_vec++;
    if (pops_l - pl0 != 1 || pops_r - pr0 != 1) begin
      n_err++; $display("FAIL single_pops got %0d/%0d want 1/1", pops_l - pl0, pops_r - pr0);
    end
    n_vec++;
    if (bad_hp - h0 != 0 || bad_edge - e0 != 0 || bad_pop - b0 != 0) begin
      n_err++; $display("FAIL single_timing hp/edge/pop errs got %0d/%0d/%0d want 0/0/0",
                        bad_hp - h0, bad_edge - e0, bad_pop - b0);
    end
  endtask

  task automatic test_back_to_back();
    int s0 = ws_log.size(), d0 = dones, pl0 = pops_l, pr0 = pops_r;
    int h0 = bad_hp, b0 = bad_pop, r0 = busy_rises;
    logic [DW-1:0] l, r;
    bit ok;
    frames.delete();
    @(posedge pclk); #2;
    for (int i = 0; i < 3; i++) begin
      l = 8'($urandom);
      r = 8'($urandom);
      lmem.push_back(l);
      rmem.push_back(r);
      frames.push_back({l, r});
    end
    i2s_enable = 1'b1;
    wait_idle(4000, ok);
    @(posedge pclk); #2 i2s_enable = 1'b0;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL b2b_timeout busy=%b want 0", busy); end
    n_vec++;
    if (ws_log.size() - s0 != 3 * FW + 1) begin
      n_err++; $display("FAIL b2b_len got %0d want %0d", ws_log.size() - s0, 3 * FW + 1);
    end
    for (int k = 0; k < 3 * FW + 1 && s0 + k < ws_log.size(); k++) begin
      n_vec++;
      if ({ws_log[s0+k], sd_log[s0+k]} !== {exp_ws(k), exp_sd(k)}) begin
        n_err++; $display("FAIL b2b_slot%0d ws/sd got %b%b want %b%b", k, ws_log[s0+k],
                          sd_log[s0+k], exp_ws(k), exp_sd(k));
      end
    end
    n_vec++;
    if (dones - d0 != 3) begin n_err++; $display("FAIL b2b_done got %0d want 3", dones - d0); end
    n_vec++;
    if (pops_l - pl0 + pops_r - pr0 != 6) begin
      n_err++; $display("FAIL b2b_pops got %0d want 6", pops_l - pl0 + pops_r - pr0);
    end
    n_vec++;
    if (busy_rises - r0 != 1 || bad_hp - h0 != 0 || bad_pop - b0 != 0) begin
      n_err++; $display("FAIL b2b_gap busy_rises/hp/pop got %0d/%0d/%0d want 1/0/0",
                        busy_rises - r0, bad_hp - h0, bad_pop - b0);
    end
  endtask

  task automatic test_enable_drop();
    int s0 = ws_log.size(), d0 = dones, pl0 = pops_l, pr0 = pops_r;
    logic [DW-1:0] l, r, l2;
    bit ok;
    frames.delete();
    @(posedge pclk); #2;
    for (int i = 0; i < 3; i++) begin
      l = 8'($urandom);
      r = 8'($urandom);
      lmem.push_back(l);
      rmem.push_back(r);
      if (i == 0) frames.push_back({l, r});
      if (i == 1) l2 = l;
    end
    i2s_enable = 1'b1;
    wait_slots(s0 + 4, 1000, ok);
    @(posedge pclk); #2 i2s_enable = 1'b0;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL drop_start_timeout slots got %0d want 4", ws_log.size() - s0); end
    wait_idle(2000, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL drop_timeout busy=%b want 0", busy); end
    n_vec++;
    if (ws_log.size() - s0 != FW + 1) begin
      n_err++; $display("FAIL drop_len got %0d want %0d", ws_log.size() - s0, FW + 1);
    end
    for (int k = 0; k < FW + 1 && s0 + k < ws_log.size(); k++) begin
      n_vec++;
      if ({ws_log[s0+k], sd_log[s0+k]} !== {exp_ws(k), exp_sd(k)}) begin
        n_err++; $display("FAIL drop_slot%0d ws/sd got %b%b want %b%b", k, ws_log[s0+k],
                          sd_log[s0+k], exp_ws(k), exp_sd(k));
      end
    end
    n_vec++;
    if (dones - d0 != 1 || pops_l - pl0 != 1 || pops_r - pr0 != 1) begin
      n_err++; $display("FAIL drop_counts done/popl/popr got %0d/%0d/%0d want 1/1/1",
                        dones - d0, pops_l - pl0, pops_r - pr0);
    end
    n_vec++;
    if (lmem.size() - lrd != 2 || rmem.size() - rrd != 2 || fifol_rdata !== l2) begin
      n_err++; $display("FAIL drop_fifo left/right/head got %0d/%0d/%h want 2/2/%h",
                        lmem.size() - lrd, rmem.size() - rrd, fifol_rdata, l2);
    end
    do_flush();
  endtask

  task automatic test_reset_mid();
    int s0 = ws_log.size(), d0 = dones;
    bit ok;
    @(posedge pclk); #2;
    lmem.push_back(8'($urandom));
    rmem.push_back(8'($urandom));
    i2s_enable = 1'b1;
    wait_slots(s0 + 6, 1000, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL rstmid_start_timeout slots got %0d want 6", ws_log.size() - s0); end
    @(posedge pclk); #2 presetn = 1'b0;
    i2s_enable = 1'b0;
    #1;
    n_vec++;
    if ({i2s_sck, i2s_ws, i2s_sd, busy} !== 4'b0100) begin
      n_err++; $display("FAIL rstmid_out sck/ws/sd/busy got %b want 0100", {i2s_sck, i2s_ws, i2s_sd, busy});
    end
    @(posedge pclk); #2 presetn = 1'b1;
    repeat (20) @(negedge pclk);
    n_vec++;
    if (dones - d0 != 0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_after done/busy got %0d/%b want 0/0", dones - d0, busy);
    end
    do_flush();
  endtask

`ifdef I2S_TX_UNDERRUN_FILL_EN
  task automatic test_underrun();
    int s0 = ws_log.size(), d0 = dones, pl0 = pops_l, pr0 = pops_r, u0 = underruns;
    bit ok;
    frames.delete();
    frames.push_back({8'h81, 8'h00});
    @(posedge pclk); #2;
    lmem.push_back(8'h81);
    i2s_enable = 1'b1;
    wait_idle(2000, ok);
    @(posedge pclk); #2 i2s_enable = 1'b0;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL udr_timeout busy=%b want 0", busy); end
    n_vec++;
    if (ws_log.size() - s0 != FW + 1) begin
      n_err++; $display("FAIL udr_len got %0d want %0d", ws_log.size() - s0, FW + 1);
    end
    for (int k = 0; k < FW + 1 && s0 + k < ws_log.size(); k++) begin
      n_vec++;
      if ({ws_log[s0+k], sd_log[s0+k]} !== {exp_ws(k), exp_sd(k)}) begin
        n_err++; $display("FAIL udr_slot%0d ws/sd got %b%b want %b%b", k, ws_log[s0+k],
                          sd_log[s0+k], exp_ws(k), exp_sd(k));
      end
    end
    n_vec++;
    if (pops_l - pl0 != 1 || pops_r - pr0 != 0 || underruns - u0 != 1 || dones - d0 != 1) begin
      n_err++; $display("FAIL udr_counts popl/popr/udr/done got %0d/%0d/%0d/%0d want 1/0/1/1",
                        pops_l - pl0, pops_r - pr0, underruns - u0, dones - d0);
    end
  endtask
`else
  task automatic test_one_empty();
    int pl0 = pops_l, pr0 = pops_r, r0 = busy_rises;
    @(posedge pclk); #2;
    lmem.push_back(8'($urandom));
    i2s_enable = 1'b1;
    repeat (60) @(negedge pclk);
    n_vec++;
    if (busy_rises - r0 != 0 || pops_l - pl0 != 0 || pops_r - pr0 != 0) begin
      n_err++; $display("FAIL one_empty busy_rises/popl/popr got %0d/%0d/%0d want 0/0/0",
                        busy_rises - r0, pops_l - pl0, pops_r - pr0);
    end
    @(posedge pclk); #2 i2s_enable = 1'b0;
    do_flush();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
`ifdef I2S_TX_UNDERRUN_FILL_EN
    test_underrun();
`else
    test_one_empty();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2s_tx_ctrl.md
I2S_TX_CTRL -- requirements
Module: i2s_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning sample width in bits (legal 8..32).
REQ-002 The block SHALL have parameter CLK_DIV, default 4, meaning pclk cycles per SCK half-period (legal 1..255).
REQ-003 Port pclk  in  1  the single clock; all logic is rising-edge pclk.
REQ-004 Port presetn  in  1  reset, asynchronous assert, active-low.
REQ-005 Port i2s_enable  in  1  CR.I2S_ENABLE level.
REQ-006 Port fifol_empty / fifor_empty  in  1 each  left/right FIFO empty flags.
REQ-007 Port fifol_rdata / fifor_rdata  in  DATA_W each  show-ahead FIFO head words, valid while not empty.
REQ-008 Port fifol_pop / fifor_pop  out  1 each  one-pclk pop strobes.
REQ-009 Port i2s_sck / i2s_ws / i2s_sd  out  1 each  I2S bit clock, word select (0=left), serial data.
REQ-010 Port i2s_tx_done  out  1  one-pclk pulse per completed frame, feeds SR.i2s_tx_done.
REQ-011 Port busy  out  1  high in any state other than IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, LOAD, RUN, DRAIN.
REQ-013 IDLE -> LOAD when i2s_enable=1 and both FIFOs non-empty; otherwise remain in IDLE.
REQ-014 LOAD SHALL last one pclk, assert fifol_pop and fifor_pop, latch both rdata words into a 2*DATA_W shift register (left in the upper half), then go to RUN.
REQ-015 In RUN, a divider SHALL count 0..CLK_DIV-1 and toggle i2s_sck at terminal count; i2s_sck is 0 on RUN entry.
REQ-016 i2s_ws and i2s_sd SHALL change only on the pclk that drives i2s_sck falling; MSB first.
REQ-017 Frame = 2*DATA_W SCK periods; i2s_ws=0 for the first DATA_W periods, 1 for the rest.
REQ-018 I2S one-bit delay: i2s_sd SHALL lag i2s_ws by one SCK period; the right-channel LSB occupies the first bit slot of the following WS=0 period.
REQ-019 On the last falling edge of a frame, i2s_tx_done SHALL pulse for one pclk.
REQ-020 On that same pclk, if i2s_enable=1 and both FIFOs non-empty, the block SHALL pop both and reload with no SCK gap (stay in RUN); otherwise go to DRAIN.
REQ-021 Deasserting i2s_enable mid-frame SHALL NOT truncate the frame; it only suppresses the reload of REQ-020.
REQ-022 DRAIN SHALL emit one SCK period with i2s_ws=0 carrying the delayed right LSB, then go to IDLE.
REQ-023 fifol_pop and fifor_pop SHALL never assert while the corresponding empty flag is 1.
REQ-024 In IDLE, outputs SHALL be i2s_sck=0, i2s_ws=1, i2s_sd=0, pops=0, i2s_tx_done=0.

Reset
REQ-025 presetn=0 SHALL asynchronously force state IDLE, divider and shift register 0, and all outputs to their REQ-024 values, including mid-frame; no pop or i2s_tx_done is generated by reset.
REQ-026 After presetn rises, the first transition is evaluated on the next pclk rising edge.

Configuration
REQ-027 Macro I2S_TX_UNDERRUN_FILL_EN SHALL select underrun handling.
REQ-028 With it defined: IDLE -> LOAD requires only i2s_enable=1 and at least one FIFO non-empty; at LOAD/reload an empty channel is loaded with zero, not popped, and an extra output port tx_underrun (out, 1) pulses for one pclk.
REQ-029 Without it: behaviour as REQ-013/REQ-020, and port tx_underrun does not exist.

Verification
REQ-030 DATA_W=8, CLK_DIV=1, L=0xA5, R=0x3C, enable once -> one LOAD pop pair; SD after WS delay = 10100101 00111100; one i2s_tx_done; DRAIN slot carries 0; busy drops.
REQ-031 Three L/R pairs queued, enable held -> three back-to-back frames, no SCK gap, three i2s_tx_done pulses, six pops total.
REQ-032 Enable dropped at bit 3 of frame 1 with more data queued -> frame 1 completes, DRAIN, IDLE; FIFOs keep the remaining data.
REQ-033 presetn pulsed low at bit 5 of a frame -> outputs immediately sck=0, ws=1, sd=0, busy=0; no i2s_tx_done.
REQ-034 CLK_DIV=3 -> every SCK half-period measures exactly 3 pclk.
REQ-035 With I2S_TX_UNDERRUN_FILL_EN, left=0x81, right FIFO empty -> right slot transmits 0x00, fifor_pop never asserts, tx_underrun pulses once.
